// File: rtl/word_deserializer_pkg.sv
// Shared definitions for the word deserializer.
// Covers the default word width, the drop counter width and the holding-register state encoding.
package word_deserializer_pkg;

  localparam int WIDTH_DEFAULT = 10;
  localparam int DROP_CNT_W    = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/word_deserializer_if.sv
// Serial-in / parallel-out bundle for word_deserializer.
// The serial side has no backpressure. On the parallel side a word transfers on any
// clock edge where io_out_valid and io_out_ready are both high, and io_out_bits holds
// steady while io_out_valid=1 and io_out_ready=0.
interface word_deserializer_if
  import word_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic                  io_in_bit;
  logic                  io_in_valid;
  logic                  io_in_sof;
  logic                  io_out_valid;
  logic                  io_out_ready;
  logic [WIDTH-1:0]      io_out_bits;
  logic                  io_overflow;
  logic [DROP_CNT_W-1:0] io_drop_count;
  hold_state_e           dbg_state;

  modport master (
    output io_in_bit, io_in_valid, io_in_sof, io_out_ready,
    input  io_out_valid, io_out_bits, io_overflow, io_drop_count, dbg_state
  );

  modport slave (
    input  io_in_bit, io_in_valid, io_in_sof, io_out_ready,
    output io_out_valid, io_out_bits, io_overflow, io_drop_count, dbg_state
  );

endinterface

// File: rtl/word_holding_reg.sv
// One-entry valid/ready output register.
// A word offered while full and not draining is dropped, which pulses overflow and bumps a saturating counter.
module word_holding_reg
  import word_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  output hold_state_e           state
);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_EMPTY;
      data       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= 1'b0;
      case (state)
        ST_EMPTY: begin
          if (load) begin
            data  <= load_data;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (ready) begin
            // Drain and refill on the same edge so back-to-back words see no bubble.
            if (load) data  <= load_data;
            else      state <= ST_EMPTY;
          end else if (load) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
          end
        end
      endcase
    end
  end

  assign valid = (state == ST_FULL);

endmodule

// File: rtl/word_deserializer.sv
// Collects serial bits into WIDTH-bit words and hands them to a one-entry output register.
// A start-of-word bit restarts assembly and silently discards any partial word.
module word_deserializer
  import word_deserializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic               clock,
  input logic               reset,
  word_deserializer_if.slave io
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] POS0     = LSB_FIRST ? '0 : CNT_LAST;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] bit_pos;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             word_done;

  // The bit index counts arrival order; the physical position mirrors it when MSB-first.
  assign bit_pos = LSB_FIRST ? cnt : (CNT_LAST - cnt);

  always_comb begin
    shreg_next = shreg;
    cnt_next   = cnt;
    word_done  = 1'b0;
    if (io.io_in_valid) begin
      if (io.io_in_sof) begin
        shreg_next       = '0;
        shreg_next[POS0] = io.io_in_bit;
        cnt_next         = CNT_W'(1);
      end else begin
        shreg_next[bit_pos] = io.io_in_bit;
        if (cnt == CNT_LAST) begin
          word_done = 1'b1;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      cnt   <= cnt_next;
      shreg <= shreg_next;
    end
  end

  // The completed word is taken from the next-state value so it lands one cycle after its last bit.
  word_holding_reg #(.WIDTH(WIDTH)) u_hold (
    .clock      (clock),
    .reset      (reset),
    .load       (word_done),
    .load_data  (shreg_next),
    .ready      (io.io_out_ready),
    .valid      (io.io_out_valid),
    .data       (io.io_out_bits),
    .overflow   (io.io_overflow),
    .drop_count (io.io_drop_count),
    .state      (io.dbg_state)
  );

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer.
// An LSB-first and an MSB-first instance see identical serial stimulus.
module tb_word_deserializer;
  import word_deserializer_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  word_deserializer_if #(.WIDTH(10)) if_lsb ();
  word_deserializer_if #(.WIDTH(10)) if_msb ();

  word_deserializer #(.WIDTH(10), .LSB_FIRST(1'b1)) dut_lsb (
    .clock (clock), .reset (reset), .io (if_lsb.slave)
  );
  word_deserializer #(.WIDTH(10), .LSB_FIRST(1'b0)) dut_msb (
    .clock (clock), .reset (reset), .io (if_msb.slave)
  );

  int checks = 0;
  int fails  = 0;

  // scoreboard: beats observed at the negative edge
  logic [9:0] got_q[$];
  logic [9:0] got_msb_q[$];
  int         beat_cyc_q[$];
  int         cyc      = 0;
  int         ovf_cnt  = 0;

  always @(negedge clock) begin
    cyc++;
    if (if_lsb.io_out_valid && if_lsb.io_out_ready) begin
      got_q.push_back(if_lsb.io_out_bits);
      beat_cyc_q.push_back(cyc);
    end
    if (if_msb.io_out_valid && if_msb.io_out_ready) got_msb_q.push_back(if_msb.io_out_bits);
    if (if_lsb.io_overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic b, input logic v, input logic s);
    if_lsb.io_in_bit = b; if_lsb.io_in_valid = v; if_lsb.io_in_sof = s;
    if_msb.io_in_bit = b; if_msb.io_in_valid = v; if_msb.io_in_sof = s;
  endtask

  task automatic set_ready(input logic r);
    if_lsb.io_out_ready = r;
    if_msb.io_out_ready = r;
  endtask

  // bit i of the stream is w[i]
  task automatic send_bits(input logic [9:0] w, input int first, input int last, input logic sof_first);
    for (int i = first; i <= last; i++) begin
      drive(w[i], 1'b1, sof_first && (i == first));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [9:0] w, input logic sof_first);
    send_bits(w, 0, 9, sof_first);
  endtask

  int base;
  int obase;

  initial begin
    drive(1'b1, 1'b1, 1'b0);
    set_ready(1'b1);
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(if_lsb.io_out_valid), 32'd0);
    check("rst_bits", 32'(if_lsb.io_out_bits), 32'd0);
    check("rst_ovf", 32'(if_lsb.io_overflow), 32'd0);
    check("rst_drop", 32'(if_lsb.io_drop_count), 32'd0);
    check("rst_state", 32'(if_lsb.dbg_state), 32'(ST_EMPTY));
    check("rst_msb_valid", 32'(if_msb.io_out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Stream 1,0,1,1,0,0,1,0,1,1 with one-cycle latency
    base = got_q.size();
    send_bits(10'h34D, 0, 8, 1'b1);
    check("lat_not_yet", 32'(if_lsb.io_out_valid), 32'd0);
    send_bits(10'h34D, 9, 9, 1'b0);
    check("lat_valid", 32'(if_lsb.io_out_valid), 32'd1);
    check("lsb_word", 32'(if_lsb.io_out_bits), 32'h34D);
    check("msb_word", 32'(if_msb.io_out_bits), 32'h2CB);
    tick();
    check("drained", 32'(if_lsb.io_out_valid), 32'd0);
    check("beat1_cnt", 32'(got_q.size() - base), 32'd1);
    check("beat1_data", 32'(got_q[base]), 32'h34D);

    // Back-to-back words
    base  = got_q.size();
    obase = ovf_cnt;
    send_word(10'h3FF, 1'b0);
    send_word(10'h001, 1'b0);
    tick();
    tick();
    check("b2b_cnt", 32'(got_q.size() - base), 32'd2);
    check("b2b_w0", 32'(got_q[base]), 32'h3FF);
    check("b2b_w1", 32'(got_q[base+1]), 32'h001);
    check("b2b_w1_msb", 32'(got_msb_q[base+1]), 32'h200);
    check("b2b_gap", 32'(beat_cyc_q[base+1] - beat_cyc_q[base]), 32'd10);
    check("b2b_no_ovf", 32'(ovf_cnt - obase), 32'd0);

    // Stalled consumer: second and third words dropped
    set_ready(1'b0);
    base  = got_q.size();
    obase = ovf_cnt;
    send_word(10'h0F0, 1'b0);
    check("stall_full", 32'(if_lsb.dbg_state), 32'(ST_FULL));
    check("stall_w0", 32'(if_lsb.io_out_bits), 32'h0F0);
    check("stall_w0_msb", 32'(if_msb.io_out_bits), 32'h03C);
    send_word(10'h123, 1'b0);
    check("stall_ovf1", 32'(if_lsb.io_overflow), 32'd1);
    check("stall_hold1", 32'(if_lsb.io_out_bits), 32'h0F0);
    send_word(10'h3C3, 1'b0);
    check("stall_ovf2", 32'(if_lsb.io_overflow), 32'd1);
    check("stall_drop2", 32'(if_lsb.io_drop_count), 32'd2);
    check("stall_hold2", 32'(if_lsb.io_out_bits), 32'h0F0);
    tick();
    check("stall_ovf_pulse", 32'(if_lsb.io_overflow), 32'd0);
    check("stall_ovf_count", 32'(ovf_cnt - obase), 32'd2);
    set_ready(1'b1);
    tick();
    check("stall_empty", 32'(if_lsb.io_out_valid), 32'd0);
    check("stall_beats", 32'(got_q.size() - base), 32'd1);
    check("stall_beat_data", 32'(got_q[base]), 32'h0F0);

    // Partial word discarded by a start-of-word
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = got_q.size();
    send_bits(10'h01F, 0, 4, 1'b1);
    send_word(10'h155, 1'b1);
    tick();
    check("sof_beats", 32'(got_q.size() - base), 32'd1);
    check("sof_word", 32'(got_q[base]), 32'h155);
    check("sof_word_msb", 32'(got_msb_q[base]), 32'h2AA);
    check("sof_drop", 32'(if_lsb.io_drop_count), 32'd0);

    // Drop counter saturation
    set_ready(1'b0);
    send_word(10'h000, 1'b0);
    for (int k = 0; k < 255; k++) send_word(10'h2AA, 1'b0);
    check("sat_255", 32'(if_lsb.io_drop_count), 32'd255);
    send_word(10'h155, 1'b0);
    check("sat_hold", 32'(if_lsb.io_drop_count), 32'd255);
    check("sat_ovf", 32'(if_lsb.io_overflow), 32'd1);
    check("sat_data", 32'(if_lsb.io_out_bits), 32'h000);

    // Reset while full and mid-word
    send_bits(10'h3FF, 0, 6, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(if_lsb.io_out_valid), 32'd0);
    check("mid_rst_bits", 32'(if_lsb.io_out_bits), 32'd0);
    check("mid_rst_ovf", 32'(if_lsb.io_overflow), 32'd0);
    check("mid_rst_drop", 32'(if_lsb.io_drop_count), 32'd0);
    check("mid_rst_msb_valid", 32'(if_msb.io_out_valid), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_ready(1'b1);
    send_word(10'h2A5, 1'b0);
    check("post_rst_valid", 32'(if_lsb.io_out_valid), 32'd1);
    check("post_rst_word", 32'(if_lsb.io_out_bits), 32'h2A5);
    check("post_rst_msb", 32'(if_msb.io_out_bits), 32'h295);
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/word_deserializer.md
WORD_DESERIALIZER -- requirements
Module: word_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning the output word width in bits; legal range 2..32.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = first serial bit lands in io_out_bits[0], 0 = first serial bit lands in io_out_bits[WIDTH-1].
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port io_in_bit, input, 1, serial data bit.
REQ-006 SHALL have port io_in_valid, input, 1, io_in_bit is sampled this cycle.
REQ-007 SHALL have port io_in_sof, input, 1, start of word: when high with io_in_valid, this bit is bit 0 of a new word.
REQ-008 SHALL have port io_out_valid, output, 1, io_out_bits holds a complete word.
REQ-009 SHALL have port io_out_ready, input, 1, consumer accepts the word when high with io_out_valid.
REQ-010 SHALL have port io_out_bits, output, WIDTH, assembled parallel word.
REQ-011 SHALL have port io_overflow, output, 1, one-cycle pulse when a completed word is dropped.
REQ-012 SHALL have port io_drop_count, output, 8, saturating count of dropped words.

Function
REQ-013 SHALL keep a bit counter cnt (0..WIDTH-1) and a WIDTH-bit shift register; no input-side backpressure (serial side never stalls).
REQ-014 On io_in_valid with io_in_sof=0: bit SHALL be written at position cnt (LSB_FIRST=1) or WIDTH-1-cnt (LSB_FIRST=0); cnt increments.
REQ-015 On io_in_valid with io_in_sof=1: any partial word SHALL be discarded silently (no overflow, no count), bit written at position 0 of new word, cnt set to 1.
REQ-016 When the bit written makes cnt reach WIDTH, the word SHALL be complete that cycle and cnt SHALL wrap to 0.
REQ-017 Cycles with io_in_valid=0 SHALL leave cnt and shift register unchanged.
REQ-018 Output side SHALL be a single holding register; states EMPTY (io_out_valid=0) and FULL (io_out_valid=1).
REQ-019 EMPTY + word complete -> FULL next cycle with io_out_bits = completed word; latency from last serial bit sampled to io_out_valid high SHALL be exactly 1 cycle.
REQ-020 FULL + io_out_ready=1 -> word transferred; if a word completes the same cycle, holding register SHALL load it and stay FULL (no bubble); otherwise -> EMPTY.
REQ-021 FULL + io_out_ready=0 + word complete -> new word SHALL be dropped, holding register unchanged, io_overflow=1 next cycle, io_drop_count increments.
REQ-022 io_drop_count SHALL saturate at 255.
REQ-023 io_out_bits SHALL be stable while io_out_valid=1 and io_out_ready=0.
REQ-024 WIDTH=1 shortcut, sof=1 on the WIDTH-th bit: io_in_sof SHALL take priority, word not completed.

Reset
REQ-025 While reset is high at a clock edge: cnt=0, shift register=0, io_out_valid=0, io_out_bits=0, io_overflow=0, io_drop_count=0.
REQ-026 Reset mid-word or with FULL holding register SHALL discard all data; inputs during reset cycles ignored.
REQ-027 First valid bit after reset deasserts SHALL be treated as bit 0 regardless of io_in_sof.

Structure
REQ-028 Shared package SHALL hold WIDTH default, drop counter width (8) and the EMPTY/FULL state encoding.
REQ-029 One sub-module is natural: word_holding_reg (1-entry valid/ready register with load/drop signalling); the shift/count logic stays in the top.

Verification
REQ-030 LSB_FIRST=1, sof on first, bits 1,0,1,1,0,0,1,0,1,1 one per cycle, ready=1 -> io_out_valid one cycle after last bit, io_out_bits=0x34D.
REQ-031 LSB_FIRST=0, same stream -> io_out_bits=0x2CB.
REQ-032 Back-to-back words 0x3FF then 0x001 at 1 bit/cycle, ready=1 -> two valid beats exactly 10 cycles apart, no overflow.
REQ-033 ready=0 held, three words sent -> io_out_bits stays first word, io_overflow pulses twice, io_drop_count=2; ready=1 -> one beat, then EMPTY.
REQ-034 5 bits then sof with 10 new bits (word 0x155) -> only 0x155 delivered, io_drop_count=0.
REQ-035 Reset asserted after 7 bits and with FULL register -> all outputs 0 next cycle; following 10 bits produce correct word.
